// File: rtl/clock_ratio_scheduler.sv
// clock_ratio_scheduler: tick and divided-clock generator whose ratio (/1,/2,/4,/8)
// changes only at divided-period boundaries.
module clock_ratio_scheduler #(
   parameter logic [1:0] RESET_SEL = 2'd0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       run,
   input  logic [1:0] sel,
   input  logic       sel_valid,
   output logic       sel_ready,
   output logic [1:0] active_sel,
   output logic       tick,
   output logic       div_clk,
   output logic       switch_done
);
   typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;
   state_t     r_state;
   logic [2:0] r_cnt;
   logic [1:0] r_pend;
   logic [1:0] r_active;
   logic       r_done;
   logic [2:0] w_term;
   logic [2:0] w_next;
   logic       w_wrap;
   logic       w_acc;
   assign w_term      = 3'((4'd1 << r_active) - 4'd1);
   assign w_wrap      = r_cnt == w_term;
   assign w_next      = w_wrap ? 3'd0 : r_cnt + 3'd1;
   assign w_acc       = sel_valid && sel_ready;
   assign sel_ready   = r_state != PEND;
   assign active_sel  = r_active;
   assign switch_done = r_done;
   assign tick        = (r_state != IDLE) && w_wrap;
   // top bit of term selects the half-period bit of cnt; zero for /1
   assign div_clk     = (r_state != IDLE) && |(r_cnt & (w_term ^ (w_term >> 1)));
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r_state  <= IDLE;
         r_cnt    <= 3'd0;
         r_pend   <= 2'd0;
         r_active <= RESET_SEL;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               r_cnt <= 3'd0;
               if (w_acc) begin
                  r_active <= sel;
                  r_done   <= 1'b1;
               end
               if (run) r_state <= RUN;
            end
            RUN:
               if (!run) begin
                  r_state <= IDLE;
                  r_cnt   <= 3'd0;
                  if (w_acc) begin
                     r_active <= sel;
                     r_done   <= 1'b1;
                  end
               end else begin
                  r_cnt <= w_next;
                  if (w_acc) begin
                     r_pend  <= sel;
                     r_state <= PEND;
                  end
               end
            PEND:
               if (!run || w_wrap) begin
                  r_active <= r_pend;
                  r_done   <= 1'b1;
                  r_cnt    <= 3'd0;
                  r_state  <= run ? RUN : IDLE;
               end else
                  r_cnt <= r_cnt + 3'd1;
            default: r_state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_clock_ratio_scheduler.sv
// tb_clock_ratio_scheduler: directed checks of ratio switching, tick/div_clk timing and reset.
module tb_clock_ratio_scheduler;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       run = 1'b0;
   logic [1:0] sel = 2'd0;
   logic       sel_valid = 1'b0;
   logic       sel_ready;
   logic [1:0] active_sel;
   logic       tick;
   logic       div_clk;
   logic       switch_done;
   int         errs = 0;
   int         checks = 0;

   clock_ratio_scheduler #(.RESET_SEL(2'd0)) dut (
      .clk(clk), .reset(reset), .run(run), .sel(sel), .sel_valid(sel_valid),
      .sel_ready(sel_ready), .active_sel(active_sel), .tick(tick),
      .div_clk(div_clk), .switch_done(switch_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [3:0] observed, input logic [3:0] expected);
      checks++;
      assert (observed === expected) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic outs(input string tag, input logic [1:0] a, input logic t, input logic d,
                       input logic r, input logic s);
      chk({tag, ".active_sel"}, {2'b0, active_sel}, {2'b0, a});
      chk({tag, ".tick"}, {3'b0, tick}, {3'b0, t});
      chk({tag, ".div_clk"}, {3'b0, div_clk}, {3'b0, d});
      chk({tag, ".sel_ready"}, {3'b0, sel_ready}, {3'b0, r});
      chk({tag, ".switch_done"}, {3'b0, switch_done}, {3'b0, s});
   endtask

   initial begin
      #3;
      outs("reset", 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      step();
      reset = 1'b0;
      run = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         outs("div1", 2'd0, 1'b1, 1'b0, 1'b1, 1'b0);
      end
      run = 1'b0;
      step();
      outs("stop", 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      sel = 2'd2;
      sel_valid = 1'b1;
      step();
      outs("idle_sel", 2'd2, 1'b0, 1'b0, 1'b1, 1'b1);
      sel_valid = 1'b0;
      run = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         outs("div4", 2'd2, (i % 4) == 3, (i % 4) >= 2, 1'b1, 1'b0);
      end
      step();
      sel = 2'd1;
      sel_valid = 1'b1;
      chk("req_ready", {3'b0, sel_ready}, 4'd1);
      step();
      sel_valid = 1'b0;
      outs("pend_c1", 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      outs("pend_c2", 2'd2, 1'b0, 1'b1, 1'b0, 1'b0);
      step();
      outs("pend_c3", 2'd2, 1'b1, 1'b1, 1'b0, 1'b0);
      step();
      outs("sw_div2", 2'd1, 1'b0, 1'b0, 1'b1, 1'b1);
      step();
      outs("div2_a", 2'd1, 1'b1, 1'b1, 1'b1, 1'b0);
      step();
      outs("div2_b", 2'd1, 1'b0, 1'b0, 1'b1, 1'b0);
      step();
      outs("div2_c", 2'd1, 1'b1, 1'b1, 1'b1, 1'b0);
      sel = 2'd3;
      sel_valid = 1'b1;
      step();
      sel = 2'd0;
      chk("pend8_ready", {3'b0, sel_ready}, 4'd0);
      step();
      sel_valid = 1'b0;
      outs("ignored", 2'd1, 1'b1, 1'b1, 1'b0, 1'b0);
      step();
      outs("sw_div8", 2'd3, 1'b0, 1'b0, 1'b1, 1'b1);
      sel = 2'd3;
      sel_valid = 1'b1;
      step();
      sel_valid = 1'b0;
      outs("same_pend", 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
      run = 1'b0;
      step();
      outs("pend_drop", 2'd3, 1'b0, 1'b0, 1'b1, 1'b1);
      run = 1'b1;
      for (int i = 0; i < 5; i++) step();
      outs("div8_c4", 2'd3, 1'b0, 1'b1, 1'b1, 1'b0);
      sel = 2'd1;
      sel_valid = 1'b1;
      step();
      sel_valid = 1'b0;
      outs("div8_pend", 2'd3, 1'b0, 1'b1, 1'b0, 1'b0);
      #2 reset = 1'b1;
      #1;
      outs("async_rst", 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      #1 reset = 1'b0;
      step();
      outs("post_rst", 2'd0, 1'b1, 1'b0, 1'b1, 1'b0);
      step();
      outs("post_rst2", 2'd0, 1'b1, 1'b0, 1'b1, 1'b0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
